alu_md_control: RTL and testbench
=================================

ALU_MD_CONTROL -- requirements
Module: alu_md_control

Interface
REQ-001 The block SHALL have parameter ALU_OP_WIDTH, default 3, width of alu_op_i.
REQ-002 The block SHALL have parameter FUNCT_WIDTH, default 6, width of alu_function_i.
REQ-003 The block SHALL have parameter MUL_CYCLES, default 32, RUN cycles for MULT/MULTU (legal 1..256).
REQ-004 The block SHALL have parameter DIV_CYCLES, default 32, RUN cycles for DIV/DIVU (legal 1..256).
REQ-005 The block SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 The block SHALL have port alu_op_i  input  ALU_OP_WIDTH  operation class from main control.
REQ-008 The block SHALL have port alu_function_i  input  FUNCT_WIDTH  instruction funct field.
REQ-009 The block SHALL have port valid_i  input  1  decode-stage instruction valid.
REQ-010 The block SHALL have port flush_i  input  1  abort in-flight mult/div, drop issue.
REQ-011 The block SHALL have port alu_operation_o  output  4  ALU operation select.
REQ-012 The block SHALL have port md_op_o  output  2  latched op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-013 The block SHALL have port md_step_o  output  1  datapath iteration enable.
REQ-014 The block SHALL have port md_count_o  output  CNT_W  iteration index, CNT_W = max(1, clog2(max(MUL_CYCLES, DIV_CYCLES))).
REQ-015 The block SHALL have port md_busy_o  output  1  sequencer not IDLE.
REQ-016 The block SHALL have port hilo_write_o  output  1  one-cycle HI/LO write strobe.
REQ-017 The block SHALL have port hilo_sel_o  output  2  read select: 00 none, 01 HI, 10 LO.
REQ-018 The block SHALL have port stall_o  output  1  hold decode stage.

Function
REQ-019 alu_operation_o SHALL be combinational from {alu_op_i, alu_function_i}: R-type (alu_op 111) ADD 100000->0011, SUB 100010->0101, OR 100101->0001, SLL 000000->0010, SRL 000010->0100, AND 100100->0110, NOR 100111->0111, SLT 101010->1000; alu_op 010->0110, 100->0011, 000->0000, 001->0001, 011->0101 (funct ignored); all else 1001.
REQ-020 Mult/div instructions SHALL be alu_op 111 with funct 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU; MFHI 010000, MFLO 010010; all drive alu_operation_o 1001.
REQ-021 Sequencer SHALL have states IDLE, RUN, DONE; md_busy_o = (state != IDLE).
REQ-022 IDLE->RUN SHALL occur when valid_i=1, flush_i=0, mult/div decoded; md_op_o latched, counter cleared to 0 on that edge.
REQ-023 In RUN, md_step_o SHALL be 1 every cycle and md_count_o SHALL increment by 1 per cycle from 0.
REQ-024 RUN->DONE SHALL occur on the cycle md_count_o = N-1, N = MUL_CYCLES for md_op_o 0x, DIV_CYCLES for 1x; N=1 gives exactly one RUN cycle.
REQ-025 In DONE, hilo_write_o SHALL be 1 for exactly that one cycle, md_step_o 0; DONE->IDLE unconditionally unless flush_i.
REQ-026 md_step_o and hilo_write_o SHALL be 0 in IDLE.
REQ-027 stall_o SHALL = valid_i AND md_busy_o AND (decoded mult/div OR MFHI OR MFLO); all other instructions SHALL not stall while busy.
REQ-028 A mult/div presented in DONE SHALL stall that cycle and be accepted from IDLE the next cycle (no back-to-back overlap).
REQ-029 hilo_sel_o SHALL be 01 for MFHI, 10 for MFLO when valid_i=1 and stall_o=0; otherwise 00.
REQ-030 flush_i=1 in RUN or DONE SHALL force IDLE next cycle, suppress hilo_write_o in that cycle, clear counter; flush_i in IDLE SHALL block issue.
REQ-031 flush_i SHALL take precedence over issue and over RUN->DONE on the same edge.

Reset
REQ-032 While reset=0 at a clock edge: state IDLE, md_count_o 0, md_op_o 00; md_busy_o, md_step_o, hilo_write_o 0 the following cycle.
REQ-033 Reset mid-RUN or in DONE SHALL abort without hilo_write_o; reset SHALL take precedence over flush_i and issue.
REQ-034 alu_operation_o, hilo_sel_o, stall_o SHALL remain combinational functions of inputs and state during reset.

Verification
REQ-035 alu_op 111, funct 100000 -> alu_operation_o 0011; alu_op 011, funct 101010 -> 0101; alu_op 101 -> 1001.
REQ-036 MULT issued, MUL_CYCLES=32 -> md_step_o high 32 cycles, md_count_o 0..31, md_op_o 00, hilo_write_o one pulse in cycle 33, md_busy_o low cycle 34.
REQ-037 DIVU issued, MFLO at cycle 5 held -> stall_o 1 until DONE exit, then hilo_sel_o 10 with stall_o 0; ADD during RUN -> stall_o 0.
REQ-038 flush_i at md_count_o 10 of DIV -> IDLE next cycle, no hilo_write_o, md_count_o 0.
REQ-039 MUL_CYCLES=1, MULT then MULTU held -> RUN 1 cycle, DONE (MULTU stalled), MULTU accepted from IDLE, md_op_o 01.
REQ-040 reset=0 asserted in RUN -> next cycle md_busy_o 0, md_step_o 0, md_count_o 0, no hilo_write_o.

Source files
------------

// File: rtl/alu_md_control.sv
// alu_md_control
//   ALU operation decode plus the sequencer for the iterative multiply/divide
//   unit. It decodes the ALU select, runs MULT/MULTU/DIV/DIVU for a fixed
//   number of iteration cycles, and strobes the HI/LO write when the result
//   is ready. It also stalls decode for any instruction that needs the
//   unit or HI/LO while the unit is still busy.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   alu_op_i        operation class from main control
//   alu_function_i  instruction funct field
//   valid_i         decode-stage instruction valid
//   flush_i         abort in-flight mult/div, drop issue
//   alu_operation_o ALU operation select (combinational)
//   md_op_o         latched op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   md_step_o       datapath iteration enable (RUN)
//   md_count_o      iteration index
//   md_busy_o       sequencer not IDLE
//   hilo_write_o    one-cycle HI/LO write strobe (DONE)
//   hilo_sel_o      HI/LO read select: 00 none, 01 HI, 10 LO
//   stall_o         hold decode stage
module alu_md_control #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int FUNCT_WIDTH  = 6,
  parameter int MUL_CYCLES   = 32,
  parameter int DIV_CYCLES   = 32,
  localparam int MAX_CYC     = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES,
  localparam int CNT_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [FUNCT_WIDTH-1:0]  alu_function_i,
  input  logic                    valid_i,
  input  logic                    flush_i,
  output logic [3:0]              alu_operation_o,
  output logic [1:0]              md_op_o,
  output logic                    md_step_o,
  output logic [CNT_W-1:0]        md_count_o,
  output logic                    md_busy_o,
  output logic                    hilo_write_o,
  output logic [1:0]              hilo_sel_o,
  output logic                    stall_o
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_RTYPE = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADDI  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ANDI  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ZERO  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ORI   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUBI  = ALU_OP_WIDTH'(3);

  localparam logic [FUNCT_WIDTH-1:0] F_ADD   = FUNCT_WIDTH'(6'b100000);
  localparam logic [FUNCT_WIDTH-1:0] F_SUB   = FUNCT_WIDTH'(6'b100010);
  localparam logic [FUNCT_WIDTH-1:0] F_OR    = FUNCT_WIDTH'(6'b100101);
  localparam logic [FUNCT_WIDTH-1:0] F_SLL   = FUNCT_WIDTH'(6'b000000);
  localparam logic [FUNCT_WIDTH-1:0] F_SRL   = FUNCT_WIDTH'(6'b000010);
  localparam logic [FUNCT_WIDTH-1:0] F_AND   = FUNCT_WIDTH'(6'b100100);
  localparam logic [FUNCT_WIDTH-1:0] F_NOR   = FUNCT_WIDTH'(6'b100111);
  localparam logic [FUNCT_WIDTH-1:0] F_SLT   = FUNCT_WIDTH'(6'b101010);
  localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(6'b011000);
  localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(6'b011001);
  localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'(6'b011010);
  localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'(6'b011011);
  localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = FUNCT_WIDTH'(6'b010000);
  localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = FUNCT_WIDTH'(6'b010010);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_op;

  logic       w_rtype;
  logic       w_is_md;
  logic       w_is_mfhi;
  logic       w_is_mflo;
  logic [1:0] w_md_code;
  logic       w_issue;
  logic       w_last;

  assign w_rtype   = (alu_op_i == OP_RTYPE);
  assign w_is_mfhi = w_rtype && (alu_function_i == F_MFHI);
  assign w_is_mflo = w_rtype && (alu_function_i == F_MFLO);

  always_comb begin
    w_is_md   = 1'b0;
    w_md_code = 2'b00;
    if (w_rtype) begin
      case (alu_function_i)
        F_MULT:  begin w_is_md = 1'b1; w_md_code = 2'b00; end
        F_MULTU: begin w_is_md = 1'b1; w_md_code = 2'b01; end
        F_DIV:   begin w_is_md = 1'b1; w_md_code = 2'b10; end
        F_DIVU:  begin w_is_md = 1'b1; w_md_code = 2'b11; end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_operation_o = 4'b1001;
    if (w_rtype) begin
      case (alu_function_i)
        F_ADD:   alu_operation_o = 4'b0011;
        F_SUB:   alu_operation_o = 4'b0101;
        F_OR:    alu_operation_o = 4'b0001;
        F_SLL:   alu_operation_o = 4'b0010;
        F_SRL:   alu_operation_o = 4'b0100;
        F_AND:   alu_operation_o = 4'b0110;
        F_NOR:   alu_operation_o = 4'b0111;
        F_SLT:   alu_operation_o = 4'b1000;
        default: ;
      endcase
    end else begin
      case (alu_op_i)
        OP_ANDI: alu_operation_o = 4'b0110;
        OP_ADDI: alu_operation_o = 4'b0011;
        OP_ZERO: alu_operation_o = 4'b0000;
        OP_ORI:  alu_operation_o = 4'b0001;
        OP_SUBI: alu_operation_o = 4'b0101;
        default: ;
      endcase
    end
  end

  // Issue only from IDLE: a mult/div arriving in DONE stalls one cycle and
  // is picked up from IDLE, so two operations never overlap.
  assign w_issue = (r_state == S_IDLE) && valid_i && !flush_i && w_is_md;
  assign w_last  = (r_count == (r_op[1] ? DIV_LAST : MUL_LAST));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= 2'b00;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_op    <= w_md_code;
          end
        end
        S_RUN: begin
          if (w_last) r_state <= S_DONE;
          else        r_count <= r_count + CNT_W'(1);
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md_op_o    = r_op;
  assign md_count_o = r_count;
  assign md_busy_o  = (r_state != S_IDLE);
  assign md_step_o  = (r_state == S_RUN);
  // The write is gated in the DONE cycle itself so an abort (flush or reset)
  // arriving in that cycle never commits a result to HI/LO.
  assign hilo_write_o = (r_state == S_DONE) && !flush_i && reset;

  assign stall_o = valid_i && md_busy_o && (w_is_md || w_is_mfhi || w_is_mflo);

  always_comb begin
    hilo_sel_o = 2'b00;
    if (valid_i && !stall_o) begin
      if (w_is_mfhi)      hilo_sel_o = 2'b01;
      else if (w_is_mflo) hilo_sel_o = 2'b10;
    end
  end

endmodule

// File: tb/tb_alu_md_control.sv
module tb_alu_md_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       valid;
  logic       flush;
  logic [3:0] alu_operation;
  logic [1:0] md_op;
  logic       md_step;
  logic [4:0] md_count;
  logic       md_busy;
  logic       hilo_write;
  logic [1:0] hilo_sel;
  logic       stall;

  // Second instance with MUL_CYCLES=1 for the single-RUN-cycle case.
  logic [2:0] alu_op1;
  logic [5:0] funct1;
  logic       valid1;
  logic       flush1;
  logic [3:0] alu_operation1;
  logic [1:0] md_op1;
  logic       md_step1;
  logic [1:0] md_count1;
  logic       md_busy1;
  logic       hilo_write1;
  logic [1:0] hilo_sel1;
  logic       stall1;

  int n_pass  = 0;
  int n_total = 0;
  int n_wr;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  alu_md_control #(.ALU_OP_WIDTH(3), .FUNCT_WIDTH(6), .MUL_CYCLES(32), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .alu_op_i(alu_op), .alu_function_i(funct),
    .valid_i(valid), .flush_i(flush), .alu_operation_o(alu_operation),
    .md_op_o(md_op), .md_step_o(md_step), .md_count_o(md_count),
    .md_busy_o(md_busy), .hilo_write_o(hilo_write), .hilo_sel_o(hilo_sel),
    .stall_o(stall)
  );

  alu_md_control #(.ALU_OP_WIDTH(3), .FUNCT_WIDTH(6), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .alu_op_i(alu_op1), .alu_function_i(funct1),
    .valid_i(valid1), .flush_i(flush1), .alu_operation_o(alu_operation1),
    .md_op_o(md_op1), .md_step_o(md_step1), .md_count_o(md_count1),
    .md_busy_o(md_busy1), .hilo_write_o(hilo_write1), .hilo_sel_o(hilo_sel1),
    .stall_o(stall1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f);
    valid  = v;
    alu_op = op;
    funct  = f;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);
    valid1 = 1'b0; flush1 = 1'b0; alu_op1 = 3'b000; funct1 = 6'b000000;
    tick(); tick();

    // Reset state, and ALU decode (combinational, valid during reset)
    #1;
    chk("rst_busy", md_busy, 0);
    chk("rst_step", md_step, 0);
    chk("rst_hw", hilo_write, 0);
    chk("rst_cnt", md_count, 0);
    chk("rst_op", md_op, 0);
    drive(1'b0, 3'b111, F_ADD);  #1; chk("alu_add", alu_operation, 4'b0011);
    drive(1'b0, 3'b011, F_SLT);  #1; chk("alu_op011", alu_operation, 4'b0101);
    drive(1'b0, 3'b101, F_ADD);  #1; chk("alu_op101", alu_operation, 4'b1001);
    drive(1'b0, 3'b111, F_SLT);  #1; chk("alu_slt", alu_operation, 4'b1000);
    drive(1'b0, 3'b010, F_ADD);  #1; chk("alu_op010", alu_operation, 4'b0110);
    drive(1'b0, 3'b111, 6'b000010); #1; chk("alu_srl", alu_operation, 4'b0100);
    drive(1'b0, 3'b111, 6'b100111); #1; chk("alu_nor", alu_operation, 4'b0111);
    drive(1'b0, 3'b111, F_MULT); #1; chk("alu_mult", alu_operation, 4'b1001);
    drive(1'b1, 3'b111, F_MFHI); #1; chk("sel_mfhi_idle", hilo_sel, 2'b01);

    // MULT, 32 RUN cycles, DONE pulse in cycle 33, idle in cycle 34
    tick();
    reset = 1'b1;
    drive(1'b1, 3'b111, F_MULT); #1;
    chk("mult_issue_stall", stall, 0);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    for (int i = 0; i < 32; i++) begin
      chk("mult_step", md_step, 1);
      chk("mult_cnt", md_count, i);
      chk("mult_hw_run", hilo_write, 0);
      tick();
    end
    chk("mult_op", md_op, 2'b00);
    chk("mult_done_hw", hilo_write, 1);
    chk("mult_done_step", md_step, 0);
    chk("mult_done_busy", md_busy, 1);
    tick();
    chk("mult_idle_busy", md_busy, 0);
    chk("mult_idle_hw", hilo_write, 0);

    // DIVU with ADD (no stall) then MFLO held until result is ready
    drive(1'b1, 3'b111, F_DIVU);
    tick();
    drive(1'b1, 3'b111, F_ADD); #1;
    chk("divu_add_stall", stall, 0);
    chk("divu_add_alu", alu_operation, 4'b0011);
    tick();
    drive(1'b1, 3'b111, F_MFLO); #1;
    for (int i = 1; i < 32; i++) begin
      chk("mflo_stall_run", stall, 1);
      chk("mflo_sel_run", hilo_sel, 2'b00);
      tick();
    end
    chk("divu_op", md_op, 2'b11);
    chk("divu_done_hw", hilo_write, 1);
    chk("mflo_stall_done", stall, 1);
    tick();
    chk("mflo_stall_idle", stall, 0);
    chk("mflo_sel_idle", hilo_sel, 2'b10);

    // DIV flushed at count 10
    drive(1'b1, 3'b111, F_DIV);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    for (int i = 0; i < 10; i++) tick();
    chk("div_cnt10", md_count, 10);
    chk("div_op", md_op, 2'b10);
    flush = 1'b1; #1;
    chk("div_flush_hw", hilo_write, 0);
    tick();
    flush = 1'b0; #1;
    chk("div_flush_busy", md_busy, 0);
    chk("div_flush_cnt", md_count, 0);
    n_wr = 0;
    for (int i = 0; i < 30; i++) begin
      if (hilo_write) n_wr++;
      tick();
    end
    chk("div_flush_nowrite", n_wr, 0);

    // Flush in IDLE blocks issue
    drive(1'b1, 3'b111, F_MULT);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000); #1;
    chk("idle_flush_busy", md_busy, 0);

    // Flush in DONE suppresses the write
    drive(1'b1, 3'b111, F_MULT);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    for (int i = 0; i < 32; i++) tick();
    chk("done_state_busy", md_busy, 1);
    flush = 1'b1; #1;
    chk("done_flush_hw", hilo_write, 0);
    tick();
    flush = 1'b0; #1;
    chk("done_flush_busy", md_busy, 0);

    // Reset in RUN, with a competing issue
    drive(1'b1, 3'b111, F_MULTU);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    for (int i = 0; i < 5; i++) tick();
    chk("rrun_cnt", md_count, 5);
    chk("rrun_op", md_op, 2'b01);
    reset = 1'b0;
    drive(1'b1, 3'b111, F_MULT);
    tick();
    reset = 1'b1;
    drive(1'b0, 3'b000, 6'b000000); #1;
    chk("rrun_busy", md_busy, 0);
    chk("rrun_step", md_step, 0);
    chk("rrun_cnt0", md_count, 0);
    chk("rrun_op0", md_op, 0);
    chk("rrun_hw", hilo_write, 0);

    // MUL_CYCLES=1: MULT then MULTU held
    valid1 = 1'b1; alu_op1 = 3'b111; funct1 = F_MULT;
    tick();
    funct1 = F_MULTU; #1;
    chk("n1_run_step", md_step1, 1);
    chk("n1_run_cnt", md_count1, 0);
    chk("n1_run_stall", stall1, 1);
    tick();
    chk("n1_done_hw", hilo_write1, 1);
    chk("n1_done_stall", stall1, 1);
    chk("n1_done_step", md_step1, 0);
    tick();
    chk("n1_idle_busy", md_busy1, 0);
    chk("n1_idle_stall", stall1, 0);
    tick();
    valid1 = 1'b0; #1;
    chk("n1_multu_step", md_step1, 1);
    chk("n1_multu_op", md_op1, 2'b01);
    tick();
    chk("n1_multu_hw", hilo_write1, 1);
    tick();
    chk("n1_final_busy", md_busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
